// File: rtl/pc_branch_unit.sv
// Program-counter stage: sequential fetch, flag-conditional jumps and
// call/return through a small LIFO return-address stack. All outputs are
// registered; flags are consumed combinationally at the advancing edge.
module pc_branch_unit #(
    parameter int AW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [2:0]    op,
    input  logic [AW-1:0] target,
    input  logic [2:0]    f,
    output logic [AW-1:0] pc,
    output logic          taken,
    output logic [3:0]    sp,
    output logic          stk_ovf,
    output logic          stk_unf
);

    // Index width for the stack array; a single-entry stack still needs one bit.
    localparam int         SW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] DEPTH_W = 4'(DEPTH);

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_JC   = 3'b010;
    localparam logic [2:0] OP_JZ   = 3'b011;
    localparam logic [2:0] OP_JN   = 3'b100;
    localparam logic [2:0] OP_JNZ  = 3'b101;
    localparam logic [2:0] OP_CALL = 3'b110;
    localparam logic [2:0] OP_RET  = 3'b111;

    logic [AW-1:0] pc_reg, pc_next;
    logic          taken_reg, taken_next;
    logic [3:0]    sp_reg, sp_next;
    logic          ovf_reg, ovf_next;
    logic          unf_reg, unf_next;
    logic          push;

    logic [AW-1:0] stack_mem [DEPTH];

    logic [AW-1:0] seq;
    logic [3:0]    sp_dec;
    logic [SW-1:0] push_idx;
    logic [SW-1:0] pop_idx;

    // Return address always wraps modulo 2^AW, same as the sequential pc.
    assign seq      = pc_reg + {{(AW-1){1'b0}}, 1'b1};
    assign sp_dec   = sp_reg - 4'd1;
    assign push_idx = sp_reg[SW-1:0];
    assign pop_idx  = sp_dec[SW-1:0];

    // Next-state decode of the branch opcode; only evaluated as a change when en=1.
    always_comb begin
        pc_next    = pc_reg;
        taken_next = 1'b0;
        sp_next    = sp_reg;
        ovf_next   = ovf_reg;
        unf_next   = unf_reg;
        push       = 1'b0;
        if (en) begin
            pc_next = seq;
            unique case (op)
                OP_NOP: pc_next = seq;
                OP_JMP: begin
                    pc_next    = target;
                    taken_next = 1'b1;
                end
                OP_JC: if (f[0]) begin
                    pc_next    = target;
                    taken_next = 1'b1;
                end
                OP_JZ: if (f[1]) begin
                    pc_next    = target;
                    taken_next = 1'b1;
                end
                OP_JN: if (f[2]) begin
                    pc_next    = target;
                    taken_next = 1'b1;
                end
                OP_JNZ: if (!f[1]) begin
                    pc_next    = target;
                    taken_next = 1'b1;
                end
                OP_CALL: begin
                    if (sp_reg < DEPTH_W) begin
                        push       = 1'b1;
                        sp_next    = sp_reg + 4'd1;
                        pc_next    = target;
                        taken_next = 1'b1;
                    end else begin
                        // Full stack: refuse the call and fall through.
                        ovf_next = 1'b1;
                    end
                end
                OP_RET: begin
                    if (sp_reg != 4'd0) begin
                        sp_next    = sp_dec;
                        pc_next    = stack_mem[pop_idx];
                        taken_next = 1'b1;
                    end else begin
                        unf_next = 1'b1;
                    end
                end
                default: pc_next = seq;
            endcase
        end
    end

    // Architectural state; reset discards any pending push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg    <= '0;
            taken_reg <= 1'b0;
            sp_reg    <= 4'd0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else begin
            pc_reg    <= pc_next;
            taken_reg <= taken_next;
            sp_reg    <= sp_next;
            ovf_reg   <= ovf_next;
            unf_reg   <= unf_next;
        end
    end

    // Return-address storage; contents are not reset, only the pointer is.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            stack_mem[push_idx] <= seq;
        end
    end

    assign pc      = pc_reg;
    assign taken   = taken_reg;
    assign sp      = sp_reg;
    assign stk_ovf = ovf_reg;
    assign stk_unf = unf_reg;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Self-checking bench for pc_branch_unit: a behavioural reference model
// pushes expected outputs per driven cycle; each test pops and compares,
// and table-driven tests also compare pc against hand-derived constants.
module tb_pc_branch_unit;

    localparam int AW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst, en;
    logic [2:0]    op;
    logic [AW-1:0] target;
    logic [2:0]    f;
    logic [AW-1:0] pc;
    logic          taken;
    logic [3:0]    sp;
    logic          stk_ovf, stk_unf;

    pc_branch_unit #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .en(en), .op(op), .target(target), .f(f),
        .pc(pc), .taken(taken), .sp(sp), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] pc;
        logic [3:0]    sp;
        logic          taken;
        logic          ovf;
        logic          unf;
    } exp_t;

    typedef struct {
        logic          r;
        logic          e;
        logic [2:0]    o;
        logic [AW-1:0] t;
        logic [2:0]    fl;
        logic [AW-1:0] pc_req;
        logic          tk_req;
    } step_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model state
    logic [AW-1:0] m_pc = '0;
    logic [3:0]    m_sp = '0;
    logic [AW-1:0] m_stk [16];
    logic          m_ovf = 1'b0, m_unf = 1'b0;

    // Drive one cycle on the falling edge, advance the model, push the
    // expectation, then step past the rising edge for sampling.
    task automatic drive(input logic r, input logic e, input logic [2:0] o,
                         input logic [AW-1:0] t, input logic [2:0] fl);
        exp_t          x;
        logic [AW-1:0] s;
        logic          tk;
        @(negedge clk);
        rst = r; en = e; op = o; target = t; f = fl;
        tk = 1'b0;
        s  = m_pc + 8'd1;
        if (r) begin
            m_pc = '0; m_sp = '0; m_ovf = 1'b0; m_unf = 1'b0;
        end else if (e) begin
            case (o)
                3'd0: m_pc = s;
                3'd1: begin m_pc = t; tk = 1'b1; end
                3'd2: begin tk = fl[0];  m_pc = tk ? t : s; end
                3'd3: begin tk = fl[1];  m_pc = tk ? t : s; end
                3'd4: begin tk = fl[2];  m_pc = tk ? t : s; end
                3'd5: begin tk = !fl[1]; m_pc = tk ? t : s; end
                3'd6: if (m_sp < DEPTH) begin
                          m_stk[m_sp] = s; m_sp = m_sp + 1; m_pc = t; tk = 1'b1;
                      end else begin
                          m_pc = s; m_ovf = 1'b1;
                      end
                default: if (m_sp > 0) begin
                          m_sp = m_sp - 1; m_pc = m_stk[m_sp]; tk = 1'b1;
                      end else begin
                          m_pc = s; m_unf = 1'b1;
                      end
            endcase
        end
        x.pc = m_pc; x.sp = m_sp; x.taken = tk; x.ovf = m_ovf; x.unf = m_unf;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t x;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 3'b001, 8'h40, 3'b111);
            x = sb.pop_front();
            vectors++;
            if ({pc, sp, taken, stk_ovf, stk_unf} !== 15'd0 ||
                {x.pc, x.sp, x.taken, x.ovf, x.unf} !== 15'd0) begin
                miscompares++;
                $display("FAIL reset: got pc=%h sp=%0d tk=%b ovf=%b unf=%b, need all zero",
                         pc, sp, taken, stk_ovf, stk_unf);
            end
        end
    endtask

    // Runs a table of steps: model comparison plus a constant pc/taken check.
    task automatic run_table(input string name, input step_t tbl[$]);
        exp_t x;
        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].e, tbl[i].o, tbl[i].t, tbl[i].fl);
            x = sb.pop_front();
            vectors++;
            if (pc !== x.pc || sp !== x.sp || taken !== x.taken ||
                stk_ovf !== x.ovf || stk_unf !== x.unf ||
                pc !== tbl[i].pc_req || taken !== tbl[i].tk_req) begin
                miscompares++;
                $display("FAIL %s[%0d]: got pc=%h sp=%0d tk=%b ovf=%b unf=%b, need pc=%h(%h) sp=%0d tk=%b(%b) ovf=%b unf=%b",
                         name, i, pc, sp, taken, stk_ovf, stk_unf, x.pc, tbl[i].pc_req,
                         x.sp, x.taken, tbl[i].tk_req, x.ovf, x.unf);
            end
        end
    endtask

    task automatic test_seq();
        step_t tbl[$] = '{
            '{0,1,3'd0,8'h00,3'b000,8'h01,0},
            '{0,1,3'd0,8'h00,3'b000,8'h02,0},
            '{0,1,3'd0,8'h00,3'b000,8'h03,0},
            '{1,1,3'd1,8'h40,3'b000,8'h00,0}
        };
        run_table("seq", tbl);
    endtask

    task automatic test_cond_jumps();
        step_t tbl[$] = '{
            '{0,1,3'd1,8'h10,3'b000,8'h10,1},
            '{0,1,3'd3,8'h80,3'b010,8'h80,1},
            '{0,1,3'd3,8'h20,3'b000,8'h81,0},
            '{0,1,3'd5,8'h20,3'b000,8'h20,1},
            '{0,1,3'd2,8'h55,3'b001,8'h55,1},
            '{0,1,3'd2,8'h99,3'b110,8'h56,0},
            '{0,1,3'd4,8'h66,3'b100,8'h66,1},
            '{0,1,3'd4,8'h99,3'b011,8'h67,0},
            '{0,1,3'd5,8'h99,3'b010,8'h68,0},
            '{0,1,3'd3,8'h69,3'b010,8'h69,1}
        };
        run_table("cond", tbl);
    endtask

    task automatic test_wrap();
        step_t tbl[$] = '{
            '{0,1,3'd1,8'hFF,3'b000,8'hFF,1},
            '{0,1,3'd0,8'h00,3'b000,8'h00,0},
            '{0,1,3'd1,8'hFF,3'b000,8'hFF,1},
            '{0,1,3'd6,8'h30,3'b000,8'h30,1},
            '{0,1,3'd7,8'h00,3'b000,8'h00,1}
        };
        run_table("wrap", tbl);
        vectors++;
        if (sp !== 4'd0) begin
            miscompares++;
            $display("FAIL wrap_sp: got sp=%0d, need 0", sp);
        end
    endtask

    task automatic test_stack_overflow();
        step_t tbl[$] = '{
            '{0,1,3'd1,8'h00,3'b000,8'h00,1},
            '{0,1,3'd6,8'h10,3'b000,8'h10,1},
            '{0,1,3'd6,8'h20,3'b000,8'h20,1},
            '{0,1,3'd6,8'h30,3'b000,8'h30,1},
            '{0,1,3'd6,8'h40,3'b000,8'h40,1},
            '{0,1,3'd6,8'h50,3'b000,8'h41,0},
            '{0,1,3'd7,8'h00,3'b000,8'h31,1},
            '{0,1,3'd7,8'h00,3'b000,8'h21,1},
            '{0,1,3'd7,8'h00,3'b000,8'h11,1},
            '{0,1,3'd7,8'h00,3'b000,8'h01,1}
        };
        run_table("stack", tbl);
        vectors++;
        if (sp !== 4'd0 || stk_ovf !== 1'b1 || stk_unf !== 1'b0) begin
            miscompares++;
            $display("FAIL stack_end: got sp=%0d ovf=%b unf=%b, need sp=0 ovf=1 unf=0",
                     sp, stk_ovf, stk_unf);
        end
    endtask

    task automatic test_underflow();
        step_t tbl[$];
        tbl.push_back('{1,0,3'd0,8'h00,3'b000,8'h00,0});
        tbl.push_back('{0,1,3'd1,8'h05,3'b000,8'h05,1});
        tbl.push_back('{0,1,3'd7,8'h00,3'b000,8'h06,0});
        for (int i = 0; i < 10; i++)
            tbl.push_back('{0,1,3'd0,8'h00,3'b000,8'(8'h07 + i),0});
        run_table("unf", tbl);
        vectors++;
        if (stk_unf !== 1'b1) begin
            miscompares++;
            $display("FAIL unf_sticky: got stk_unf=%b, need 1", stk_unf);
        end
        tbl.delete();
        tbl.push_back('{1,1,3'd7,8'h00,3'b000,8'h00,0});
        run_table("unf_clr", tbl);
        vectors++;
        if (stk_unf !== 1'b0 || stk_ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL unf_clear: got unf=%b ovf=%b, need 0 0", stk_unf, stk_ovf);
        end
    endtask

    task automatic test_hold();
        step_t tbl[$];
        tbl.push_back('{0,1,3'd6,8'h3C,3'b000,8'h3C,1});
        tbl.push_back('{0,1,3'd7,8'h00,3'b000,8'h01,1});
        tbl.push_back('{0,1,3'd7,8'h00,3'b000,8'h02,0});
        tbl.push_back('{0,1,3'd6,8'h3C,3'b000,8'h3C,1});
        for (int i = 0; i < 5; i++)
            tbl.push_back('{0,0,3'd1,8'h99,3'b111,8'h3C,0});
        tbl.push_back('{0,1,3'd2,8'h77,3'b001,8'h77,1});
        run_table("hold", tbl);
        vectors++;
        if (sp !== 4'd1 || stk_unf !== 1'b1 || stk_ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_state: got sp=%0d unf=%b ovf=%b, need sp=1 unf=1 ovf=0",
                     sp, stk_unf, stk_ovf);
        end
    endtask

    // Random back-to-back traffic checked only against the reference model.
    task automatic test_back_to_back();
        exp_t x;
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 4) != 0),
                  3'($urandom_range(0, 7)), 8'($urandom), 3'($urandom));
            x = sb.pop_front();
            vectors++;
            if (pc !== x.pc || sp !== x.sp || taken !== x.taken ||
                stk_ovf !== x.ovf || stk_unf !== x.unf) begin
                miscompares++;
                $display("FAIL b2b[%0d]: got pc=%h sp=%0d tk=%b ovf=%b unf=%b, need pc=%h sp=%0d tk=%b ovf=%b unf=%b",
                         i, pc, sp, taken, stk_ovf, stk_unf, x.pc, x.sp, x.taken, x.ovf, x.unf);
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; op = 3'd0; target = '0; f = 3'd0;
        test_reset();
        test_seq();
        test_cond_jumps();
        test_wrap();
        test_stack_overflow();
        test_underflow();
        test_hold();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
- Program-counter stage of the 8-bit processor. It sits downstream of the flag register and consumes its 3-bit flag vector f (f[0]=carry, f[1]=zero, f[2]=sign).
- Each enabled cycle it computes the next instruction address: sequential increment, unconditional or flag-conditional jump, or call/return through a small internal return-address stack.
- The registered pc drives instruction fetch.

Parameters:
- AW, 8, address width of pc, target and stack entries.
- DEPTH, 4, number of return-stack entries; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset, sampled on posedge clk.
- en  input  1  advance strobe; when 0, all state holds.
- op  input  3  branch opcode, sampled when en=1.
- target  input  AW  jump/call destination.
- f  input  3  flags from flag register: [0]=carry, [1]=zero, [2]=sign.
- pc  output  AW  registered current instruction address.
- taken  output  1  registered; 1 for the cycle after a redirect (jump taken, CALL pushed, RET popped).
- sp  output  4  registered stack occupancy, 0..DEPTH.
- stk_ovf  output  1  sticky: CALL attempted while stack full.
- stk_unf  output  1  sticky: RET attempted while stack empty.

Behaviour:
- Reset:
  - rst=1 at posedge: pc=0, taken=0, sp=0, stk_ovf=0, stk_unf=0.
  - Stack entry contents are don't-care after reset.
  - rst overrides en and op, including mid-call; any pending push or pop is discarded.
- en=0: pc, sp, stack and sticky flags hold; taken <= 0.
- en=1 decode; "seq" means pc+1 modulo 2^AW:
  - 000 NOP: pc <= seq.
  - 001 JMP: pc <= target.
  - 010 JC: pc <= f[0] ? target : seq.
  - 011 JZ: pc <= f[1] ? target : seq.
  - 100 JN: pc <= f[2] ? target : seq.
  - 101 JNZ: pc <= f[1] ? seq : target.
  - 110 CALL, sp<DEPTH: stack[sp] <= seq; sp <= sp+1; pc <= target.
  - 110 CALL, sp==DEPTH: no push; pc <= seq; stk_ovf <= 1.
  - 111 RET, sp>0: pc <= stack[sp-1]; sp <= sp-1.
  - 111 RET, sp==0: pc <= seq; stk_unf <= 1.
- taken <= 1 exactly when pc was loaded from target or from the stack; otherwise 0. A conditional jump whose target equals seq still asserts taken.
- Latency: flags and op sampled at edge N determine pc visible after edge N. f must be stable at that edge; it is not registered internally.
- Wrap: pc=2^AW-1 with seq gives pc=0. The pushed return address wraps the same way (CALL at 0xFF pushes 0x00).
- Sticky stk_ovf and stk_unf clear only on rst; both may be set at once.
- Stack is LIFO, with no wrap or overwrite on overflow.

Test Plan:
- Reset then en=1, op=000 for 3 cycles -> pc 0,1,2,3; taken=0 throughout. Assert rst while op=001, target=0x40 -> pc=0 next cycle, taken=0.
- pc=0x10, f=3'b010: JZ target=0x80 -> pc=0x80, taken=1. Then f=3'b000: JZ target=0x20 -> pc=0x81, taken=0. Then JNZ target=0x20 -> pc=0x20, taken=1.
- pc=0xFF, op=000 -> pc=0x00. Set pc=0xFF via JMP 0xFF, then CALL target=0x30 -> pc=0x30, sp=1; RET -> pc=0x00, sp=0.
- DEPTH=4, from pc=0x00:
  - CALLs to 0x10, 0x20, 0x30, 0x40 -> sp=4.
  - 5th CALL to 0x50 -> pc=0x41, sp=4, stk_ovf=1, taken=0.
  - 4 RETs -> pc 0x31, 0x21, 0x11, 0x01, sp=0.
- sp=0, RET at pc=0x05 -> pc=0x06, stk_unf=1, taken=0. stk_unf stays 1 through 10 NOPs; clears only after rst.
- en=0 for 5 cycles with op=001, target=0x99 -> pc, sp and flags unchanged, taken=0. JC with f[0]=1, target=0x77 on the next en=1 cycle -> pc=0x77, taken=1.
